// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_stage
//  Purpose  : Decode-path immediate generator. Classifies the immediate
//             format of each accepted instruction, extends it to XLEN and
//             buffers the result in a small in-order FIFO that absorbs
//             execute-stage backpressure and can be flushed on redirect.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_stage #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter bit EN_ZIMM   = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [31:0]                    inst_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [XLEN-1:0]                imm_ext_o,
    output logic [2:0]                     imm_type_o,
    output logic                           illegal_o,
    output logic [31:0]                    inst_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] C_T_NONE = 3'd0;
    localparam logic [2:0] C_T_I    = 3'd1;
    localparam logic [2:0] C_T_S    = 3'd2;
    localparam logic [2:0] C_T_B    = 3'd3;
    localparam logic [2:0] C_T_U    = 3'd4;
    localparam logic [2:0] C_T_J    = 3'd5;
    localparam logic [2:0] C_T_Z    = 3'd6;

    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_ALUI   = 7'b0010011;
    localparam logic [6:0] C_OP_ALU    = 7'b0110011;
    localparam logic [6:0] C_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [2:0]      w_type;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm_ext;
    logic            w_sign;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] imm_mem_q  [BUF_DEPTH];
    logic [2:0]      type_mem_q [BUF_DEPTH];
    logic            ill_mem_q  [BUF_DEPTH];
    logic [31:0]     inst_mem_q [BUF_DEPTH];

    // ------------------------------------------------------------------
    // Immediate decode
    // ------------------------------------------------------------------
    assign w_sign = inst_i[31];

    // Classify the opcode and assemble the 32-bit immediate
    always_comb begin
        w_imm32   = 32'd0;
        w_type    = C_T_NONE;
        w_illegal = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (inst_i[6:0])
                C_OP_LUI, C_OP_AUIPC: begin
                    w_type  = C_T_U;
                    w_imm32 = {inst_i[31:12], 12'd0};
                end
                C_OP_JAL: begin
                    w_type  = C_T_J;
                    w_imm32 = {{11{w_sign}}, inst_i[31], inst_i[19:12],
                               inst_i[20], inst_i[30:21], 1'b0};
                end
                C_OP_BRANCH: begin
                    w_type  = C_T_B;
                    w_imm32 = {{19{w_sign}}, inst_i[31], inst_i[7],
                               inst_i[30:25], inst_i[11:8], 1'b0};
                end
                C_OP_STORE: begin
                    w_type  = C_T_S;
                    w_imm32 = {{20{w_sign}}, inst_i[31:25], inst_i[11:7]};
                end
                C_OP_JALR, C_OP_LOAD, C_OP_ALUI: begin
                    w_type  = C_T_I;
                    w_imm32 = {{20{w_sign}}, inst_i[31:20]};
                end
                C_OP_SYSTEM: begin
                    // CSR-immediate forms carry a 5-bit unsigned zimm in rs1
                    if (EN_ZIMM && inst_i[14]) begin
                        w_type  = C_T_Z;
                        w_imm32 = {27'd0, inst_i[19:15]};
                    end else begin
                        w_type  = C_T_I;
                        w_imm32 = {{20{w_sign}}, inst_i[31:20]};
                    end
                end
                C_OP_ALU, C_OP_FENCE: begin
                    w_type  = C_T_NONE;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Widen to XLEN. Bit 31 of w_imm32 already holds the correct extension
    // bit for every format (0 for zimm and for illegal/NONE).
    generate
        if (XLEN > 32) begin : g_ext_wide
            assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_ext_narrow
            assign w_imm_ext = w_imm32[XLEN-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_nonempty  = (count_q != '0);
    assign out_valid_o = w_nonempty;
    assign in_ready_o  = rst_ni && !flush_i && ((count_q < C_DEPTH) || out_ready_i);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = w_nonempty && out_ready_i;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // Next-state for occupancy and both circular pointers
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + C_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset and flush both empty the buffer
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Result storage; contents are only observable while count_q != 0
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            imm_mem_q[wr_ptr_q]  <= w_imm_ext;
            type_mem_q[wr_ptr_q] <= w_type;
            ill_mem_q[wr_ptr_q]  <= w_illegal;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

    // ------------------------------------------------------------------
    // Head-entry outputs, forced to zero when empty
    // ------------------------------------------------------------------
    assign imm_ext_o  = w_nonempty ? imm_mem_q[rd_ptr_q]  : '0;
    assign imm_type_o = w_nonempty ? type_mem_q[rd_ptr_q] : C_T_NONE;
    assign illegal_o  = w_nonempty ? ill_mem_q[rd_ptr_q]  : 1'b0;
    assign inst_o     = w_nonempty ? inst_mem_q[rd_ptr_q] : 32'd0;
    assign count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_stage
//  Purpose  : Directed self-checking bench for imm_gen_stage. Three instances
//             share stimulus: XLEN=32/EN_ZIMM=1, XLEN=64, XLEN=32/EN_ZIMM=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        out_ready_i;
    logic [31:0] inst_i;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a, inst_a;
    logic [2:0]  type_a;
    logic [1:0]  count_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [31:0] inst_b;
    logic [2:0]  type_b;
    logic [1:0]  count_b;

    logic        in_ready_c, out_valid_c, illegal_c;
    logic [31:0] imm_c, inst_c;
    logic [2:0]  type_c;
    logic [1:0]  count_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    imm_gen_stage #(.XLEN(32), .BUF_DEPTH(2), .EN_ZIMM(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_a), .inst_i(inst_i),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_i),
        .imm_ext_o(imm_a), .imm_type_o(type_a), .illegal_o(illegal_a),
        .inst_o(inst_a), .count_o(count_a)
    );

    imm_gen_stage #(.XLEN(64), .BUF_DEPTH(2), .EN_ZIMM(1'b1)) dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_b), .inst_i(inst_i),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
        .imm_ext_o(imm_b), .imm_type_o(type_b), .illegal_o(illegal_b),
        .inst_o(inst_b), .count_o(count_b)
    );

    imm_gen_stage #(.XLEN(32), .BUF_DEPTH(2), .EN_ZIMM(1'b0)) dut_noz (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_c), .inst_i(inst_i),
        .out_valid_o(out_valid_c), .out_ready_i(out_ready_i),
        .imm_ext_o(imm_c), .imm_type_o(type_c), .illegal_o(illegal_c),
        .inst_o(inst_c), .count_o(count_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Push one instruction into an empty FIFO with the consumer ready,
    // check the head one cycle later, then let it drain.
    task automatic send_check(input logic [31:0] inst, input logic [31:0] e32,
                              input logic [63:0] e64, input logic [2:0] etype,
                              input logic eill, input logic [31:0] eimm_nz,
                              input logic [2:0] etype_nz);
        inst_i      = inst;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("vec_valid", 64'(out_valid_a), 64'd1);
        check("vec_count", 64'(count_a), 64'd1);
        check("vec_imm32", 64'(imm_a), 64'(e32));
        check("vec_type",  64'(type_a), 64'(etype));
        check("vec_ill",   64'(illegal_a), 64'(eill));
        check("vec_inst",  64'(inst_a), 64'(inst));
        check("vec_imm64", imm_b, e64);
        check("vec_imm_nz", 64'(imm_c), 64'(eimm_nz));
        check("vec_type_nz", 64'(type_c), 64'(etype_nz));
        tick();
        check("vec_drain", 64'(count_a), 64'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        inst_i      = 32'd0;
        tick();
        tick();
        check("rst_count", 64'(count_a), 64'd0);
        check("rst_valid", 64'(out_valid_a), 64'd0);
        check("rst_imm",   64'(imm_a), 64'd0);
        check("rst_ready", 64'(in_ready_a), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("ready_after_rst", 64'(in_ready_a), 64'd1);

        // Format vectors: inst, imm32, imm64, type, illegal, imm/type with EN_ZIMM=0
        send_check(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1);
        send_check(32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0, 32'h80000000, 3'd4);
        send_check(32'hFE000FE3, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE, 3'd3, 1'b0, 32'hFFFFFFFE, 3'd3);
        send_check(32'h3400D073, 32'h00000001, 64'h00000000_00000001, 3'd6, 1'b0, 32'h00000340, 3'd1);
        send_check(32'h008000EF, 32'h00000008, 64'h00000000_00000008, 3'd5, 1'b0, 32'h00000008, 3'd5);
        send_check(32'hFE20AFA3, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd2, 1'b0, 32'hFFFFFFFF, 3'd2);
        send_check(32'h002081B3, 32'h00000000, 64'h0,                 3'd0, 1'b0, 32'h00000000, 3'd0);
        send_check(32'h00000000, 32'h00000000, 64'h0,                 3'd0, 1'b1, 32'h00000000, 3'd0);
        send_check(32'h0000007F, 32'h00000000, 64'h0,                 3'd0, 1'b1, 32'h00000000, 3'd0);

        // Backpressure: three back-to-back pushes into a depth-2 FIFO
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'hFFF00093;
        tick();
        check("bp_count1", 64'(count_a), 64'd1);
        inst_i = 32'h800000B7;
        tick();
        check("bp_count2", 64'(count_a), 64'd2);
        check("bp_ready_low", 64'(in_ready_a), 64'd0);
        inst_i = 32'h002081B3;
        tick();
        check("bp_hold_count", 64'(count_a), 64'd2);
        check("bp_head_a", 64'(inst_a), 64'hFFF00093);
        out_ready_i = 1'b1;
        #1;
        check("bp_ready_rise", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_i = 1'b0;
        check("bp_full_swap_count", 64'(count_a), 64'd2);
        check("bp_head_b", 64'(inst_a), 64'h800000B7);
        check("bp_head_b_imm", 64'(imm_a), 64'h80000000);
        tick();
        check("bp_head_c", 64'(inst_a), 64'h002081B3);
        check("bp_count_c", 64'(count_a), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid_a), 64'd0);
        check("bp_empty_inst", 64'(inst_a), 64'd0);

        // Throughput: one per cycle with the consumer always ready
        in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_i = 32'h00100093 + (32'(i) << 20);
            tick();
            check("tp_inst", 64'(inst_a), 64'(32'h00100093 + (32'(i) << 20)));
            check("tp_count", 64'(count_a), 64'd1);
        end
        in_valid_i = 1'b0;
        tick();

        // Flush of a full FIFO with a same-cycle push and pop
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'hFFF00093;
        tick();
        tick();
        check("fl_full", 64'(count_a), 64'd2);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        inst_i      = 32'h0AA00093;
        #1;
        check("fl_ready_low", 64'(in_ready_a), 64'd0);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_count", 64'(count_a), 64'd0);
        check("fl_valid", 64'(out_valid_a), 64'd0);
        check("fl_inst",  64'(inst_a), 64'd0);
        tick();
        check("fl_no_ghost", 64'(out_valid_a), 64'd0);

        // Reset mid-stream with two entries buffered
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h800000B7;
        tick();
        tick();
        in_valid_i = 1'b0;
        check("rs_full", 64'(count_a), 64'd2);
        rst_ni = 1'b0;
        tick();
        check("rs_count", 64'(count_a), 64'd0);
        check("rs_valid", 64'(out_valid_a), 64'd0);
        check("rs_imm",   64'(imm_a), 64'd0);
        check("rs_imm64", imm_b, 64'd0);
        check("rs_type",  64'(type_a), 64'd0);
        check("rs_ill",   64'(illegal_a), 64'd0);
        check("rs_inst",  64'(inst_a), 64'd0);
        check("rs_ready", 64'(in_ready_a), 64'd0);
        rst_ni = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
